// File: rtl/prefetch_if.sv
// Fetch-side bus between the prefetch unit, the instruction port, the redirect
// source and decode.
interface prefetch_if #(
   parameter int unsigned DEPTH = 4
) ();
   logic                             iren;
   logic [31:0]                      iaddr;
   logic                             iwait;
   logic [31:0]                      iload;
   logic                             redirect;
   logic [31:0]                      redirect_pc;
   logic                             fetch_halt;
   logic                             out_valid;
   logic [31:0]                      out_pc;
   logic [31:0]                      out_inst;
   logic                             out_ready;
   logic [$clog2(DEPTH+1)-1:0]       count;

   // Prefetch unit side.
   modport master (
      output iren, iaddr, out_valid, out_pc, out_inst, count,
      input  iwait, iload, redirect, redirect_pc, fetch_halt, out_ready
   );

   // Memory / pipeline / decode side.
   modport slave (
      input  iren, iaddr, out_valid, out_pc, out_inst, count,
      output iwait, iload, redirect, redirect_pc, fetch_halt, out_ready
   );
endinterface

// File: rtl/prefetch_unit.sv
// Decoupled instruction fetch: owns the fetch PC, issues sequential reads and
// queues returned {pc, inst} pairs for decode; redirects flush and restart.
module prefetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter int unsigned DEPTH   = 4,
   parameter logic [31:0] NOP     = 32'h0000_0013
) (
   input logic        clk,
   input logic        rst,
   prefetch_if.master bus
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [CntW-1:0] Full = CntW'(DEPTH);

   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [31:0]     mem_pc_q   [DEPTH];
   logic [31:0]     mem_inst_q [DEPTH];

   logic out_valid;
   logic pop;
   logic space;
   logic iren;
   logic push;

   always_comb begin
      out_valid = (count_q != '0);
      // Raw pop for space: a full queue may refill while decode drains it.
      space     = (count_q < Full) | (out_valid & bus.out_ready);
      iren      = ~rst & ~bus.fetch_halt & space & ~bus.redirect;
      push      = iren & ~bus.iwait;
      pop       = out_valid & bus.out_ready & ~bus.redirect;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rptr_d     = rptr_q;
      wptr_d     = wptr_q;
      count_d    = count_q;
      if (bus.redirect) begin
         fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
         rptr_d     = '0;
         wptr_d     = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            wptr_d     = wptr_q + PtrW'(1);
         end
         if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= PC_INIT;
         rptr_q     <= '0;
         wptr_q     <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rptr_q     <= rptr_d;
         wptr_q     <= wptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible while count is nonzero.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc_q[wptr_q]   <= fetch_pc_q;
         mem_inst_q[wptr_q] <= bus.iload;
      end
   end

   assign bus.iren      = iren;
   assign bus.iaddr     = fetch_pc_q;
   assign bus.out_valid = out_valid;
   assign bus.out_pc    = out_valid ? mem_pc_q[rptr_q] : fetch_pc_q;
   assign bus.out_inst  = out_valid ? mem_inst_q[rptr_q] : NOP;
   assign bus.count     = count_q;
endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_prefetch_unit;
   localparam int unsigned DEPTH   = 4;
   localparam logic [31:0] PC_INIT = 32'h0000_0000;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   prefetch_if #(.DEPTH(DEPTH)) bus ();

   prefetch_unit #(
      .PC_INIT (PC_INIT),
      .DEPTH   (DEPTH),
      .NOP     (NOP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a queue of {pc, inst} and the next PC to fetch.
   logic [63:0] model_q[$];
   logic [31:0] model_pc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input logic exp_iren);
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_inst;
      logic [63:0] head;
      exp_valid = (model_q.size() != 0);
      if (exp_valid) begin
         head     = model_q[0];
         exp_pc   = head[63:32];
         exp_inst = head[31:0];
      end else begin
         exp_pc   = model_pc;
         exp_inst = NOP;
      end
      check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      check("out_pc", bus.out_pc, exp_pc);
      check("out_inst", bus.out_inst, exp_inst);
      check("count", 32'(bus.count), model_q.size());
      check("iaddr", bus.iaddr, model_pc);
      check("iren", 32'(bus.iren), 32'(exp_iren));
   endtask

   // Apply one cycle of inputs, check, advance the model, then cross the edge.
   task automatic step(input logic h, input logic rd, input logic [31:0] rpc,
                       input logic w, input logic [31:0] ld, input logic rdy);
      logic has_room;
      logic exp_iren;
      logic do_pop;
      bus.fetch_halt  = h;
      bus.redirect    = rd;
      bus.redirect_pc = rpc;
      bus.iwait       = w;
      bus.iload       = ld;
      bus.out_ready   = rdy;
      #1;
      do_pop   = (model_q.size() != 0) && rdy;
      has_room = (model_q.size() < DEPTH) || do_pop;
      exp_iren = !h && !rd && has_room;
      check_outputs(exp_iren);
      if (rd) begin
         model_q.delete();
         model_pc = rpc & 32'hFFFF_FFFC;
      end else begin
         if (do_pop) void'(model_q.pop_front());
         if (exp_iren && !w) begin
            model_q.push_back({model_pc, ld});
            model_pc = model_pc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared        = 0;
      mismatched      = 0;
      model_pc        = PC_INIT;
      rst             = 1'b1;
      bus.fetch_halt  = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.iwait       = 1'b0;
      bus.iload       = '0;
      bus.out_ready   = 1'b0;
      #2;
      check_outputs(1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Streaming with decode always ready: occupancy settles at 1.
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b0, $urandom, 1'b1);

      // Fill to full with decode stalled, then drain while refilling.
      step(1'b0, 1'b1, 32'h0, 1'b0, $urandom, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b0, $urandom, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b0, $urandom, 1'b1);

      // Redirect to a misaligned target with 3 entries queued and a concurrent hit.
      step(1'b0, 1'b1, 32'h0, 1'b0, $urandom, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0, $urandom, 1'b0);
      step(1'b0, 1'b1, 32'h103, 1'b0, 32'hDEAD_BEEF, 1'b1);
      check("redir_iaddr", bus.iaddr, 32'h100);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0, $urandom, 1'b1);

      // Three-cycle miss at 0x20, then a hit.
      step(1'b0, 1'b1, 32'h20, 1'b0, $urandom, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, $urandom, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 32'h1234_5678, 1'b1);
      check("stall_pc", bus.out_pc, 32'h20);
      step(1'b0, 1'b0, '0, 1'b0, $urandom, 1'b0);

      // Halt with two entries queued; reset asynchronously mid-drain.
      step(1'b0, 1'b1, 32'h400, 1'b0, $urandom, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b0, $urandom, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, $urandom, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      model_q.delete();
      model_pc = PC_INIT;
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_pc", bus.out_pc, PC_INIT);
      check_outputs(1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 2), ($urandom_range(0, 19) == 0), $urandom,
              ($urandom_range(0, 9) < 3), $urandom, ($urandom_range(0, 9) < 6));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
